// File: rtl/idct_pkg.sv
// Shared constants and types for the 4-point IDCT front end.
package idct_pkg;

    localparam int N         = 4;
    localparam int DRAIN_LEN = 7;
    localparam int IDCT_IN_W = 25;
    localparam int COEFF_W   = 16;

    typedef logic signed [COEFF_W-1:0]   coeff_t;
    typedef logic signed [IDCT_IN_W-1:0] lane_t;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_state_t;

    typedef enum logic {
        IDLE,
        DRAIN
    } rd_state_t;

endpackage

// File: rtl/idct_blk_bank.sv
// One 4x4 coefficient bank: a whole row is written per beat, and each of the
// four read ports returns one element of its own row at a chosen column.
module idct_blk_bank
    import idct_pkg::*;
#(
    parameter int W = COEFF_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [1:0]            wr_row,
    input  logic [N-1:0][W-1:0]   wr_data,
    input  logic [N-1:0][1:0]     rd_col,
    output logic [N-1:0][W-1:0]   rd_data
);

    logic [N-1:0][N-1:0][W-1:0] mem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem <= '0;
        end else if (wr_en) begin
            mem[wr_row] <= wr_data;
        end
    end

    // Read port k is hard-wired to row k; only the column varies.
    for (genvar k = 0; k < N; k++) begin : g_rd
        assign rd_data[k] = mem[k][rd_col[k]];
    end

endmodule

// File: rtl/idct4_skew_feeder.sv
// Ping-pong 4x4 block buffer that drains each block column by column with a
// one-cycle diagonal skew per lane, feeding the systolic IDCT column element.
module idct4_skew_feeder
    import idct_pkg::*;
#(
    parameter int IN_W  = COEFF_W,
    parameter int OUT_W = IDCT_IN_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_c0,
    input  logic signed [IN_W-1:0]  in_c1,
    input  logic signed [IN_W-1:0]  in_c2,
    input  logic signed [IN_W-1:0]  in_c3,
    output logic signed [OUT_W-1:0] d_out_1,
    output logic signed [OUT_W-1:0] d_out_2,
    output logic signed [OUT_W-1:0] d_out_3,
    output logic signed [OUT_W-1:0] d_out_4,
    output logic [3:0]              lane_valid,
    output logic                    blk_start,
    output logic                    blk_done
);

    localparam logic [2:0] T_LAST = 3'(DRAIN_LEN - 1);

    bank_state_t bank_st [2];
    bank_state_t bank_nxt [2];
    rd_state_t   rd_st, rd_nxt;
    logic        wr_sel, wr_sel_nxt, rd_sel, rd_sel_nxt, rd_other;
    logic [1:0]  wr_row, wr_row_nxt;
    logic [2:0]  t, t_nxt;
    logic        accept, ready_nxt;

    logic [N-1:0][IN_W-1:0]  wr_data;
    logic [N-1:0][1:0]       rd_col;
    logic [N-1:0][IN_W-1:0]  rd_data0, rd_data1, lane_elem;
    logic [N-1:0]            lane_ok;
    logic [N-1:0][OUT_W-1:0] lane_nxt, lane_q;

    assign accept   = in_valid & in_ready;
    assign rd_other = ~rd_sel;
    assign wr_data  = {in_c3, in_c2, in_c1, in_c0};

    // Writer and reader only ever touch disjoint bank states, so both may
    // update bank_nxt in the same cycle without conflict.
    always_comb begin
        bank_nxt   = bank_st;
        wr_sel_nxt = wr_sel;
        wr_row_nxt = wr_row;
        rd_sel_nxt = rd_sel;
        rd_nxt     = rd_st;
        t_nxt      = t;

        if (accept) begin
            wr_row_nxt = wr_row + 2'd1;
            if (wr_row == 2'd3) begin
                bank_nxt[wr_sel] = FULL;
                wr_sel_nxt       = ~wr_sel;
            end else begin
                bank_nxt[wr_sel] = FILLING;
            end
        end

        case (rd_st)
            IDLE: begin
                if (bank_st[rd_sel] == FULL) begin
                    bank_nxt[rd_sel] = DRAINING;
                    rd_nxt           = DRAIN;
                    t_nxt            = '0;
                end
            end
            DRAIN: begin
                if (t == T_LAST) begin
                    bank_nxt[rd_sel] = EMPTY;
                    rd_sel_nxt       = rd_other;
                    t_nxt            = '0;
                    if (bank_st[rd_other] == FULL) begin
                        bank_nxt[rd_other] = DRAINING;
                    end else begin
                        rd_nxt = IDLE;
                    end
                end else begin
                    t_nxt = t + 3'd1;
                end
            end
            default: rd_nxt = IDLE;
        endcase

        ready_nxt = (bank_nxt[wr_sel_nxt] == EMPTY) ||
                    (bank_nxt[wr_sel_nxt] == FILLING);
    end

    idct_blk_bank #(.W(IN_W)) u_bank0 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept & ~wr_sel),
        .wr_row  (wr_row),
        .wr_data (wr_data),
        .rd_col  (rd_col),
        .rd_data (rd_data0)
    );

    idct_blk_bank #(.W(IN_W)) u_bank1 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept & wr_sel),
        .wr_row  (wr_row),
        .wr_data (wr_data),
        .rd_col  (rd_col),
        .rd_data (rd_data1)
    );

    // Lane k shows column (t - k) of row k while that column index is 0..3.
    for (genvar k = 0; k < N; k++) begin : g_lane
        assign lane_ok[k]   = (rd_nxt == DRAIN) && (t_nxt >= 3'(k)) && (t_nxt <= 3'(k + 3));
        assign rd_col[k]    = 2'(t_nxt - 3'(k));
        assign lane_elem[k] = rd_sel_nxt ? rd_data1[k] : rd_data0[k];
        assign lane_nxt[k]  = lane_ok[k]
                            ? {{(OUT_W - IN_W){lane_elem[k][IN_W-1]}}, lane_elem[k]}
                            : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            wr_row     <= '0;
            rd_st      <= IDLE;
            t          <= '0;
            in_ready   <= 1'b0;
            lane_q     <= '0;
            lane_valid <= '0;
            blk_start  <= 1'b0;
            blk_done   <= 1'b0;
        end else begin
            bank_st    <= bank_nxt;
            wr_sel     <= wr_sel_nxt;
            rd_sel     <= rd_sel_nxt;
            wr_row     <= wr_row_nxt;
            rd_st      <= rd_nxt;
            t          <= t_nxt;
            in_ready   <= ready_nxt;
            lane_q     <= lane_nxt;
            lane_valid <= lane_ok;
            blk_start  <= (rd_nxt == DRAIN) && (t_nxt == 3'd0);
            blk_done   <= (rd_nxt == DRAIN) && (t_nxt == T_LAST);
        end
    end

    assign d_out_1 = lane_q[0];
    assign d_out_2 = lane_q[1];
    assign d_out_3 = lane_q[2];
    assign d_out_4 = lane_q[3];

endmodule

// File: tb/tb_idct4_skew_feeder.sv
// Self-checking bench for idct4_skew_feeder: block-level timing model plus
// hand-computed spot checks.
module tb_idct4_skew_feeder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0;
    logic signed [15:0] in_c0 = '0, in_c1 = '0, in_c2 = '0, in_c3 = '0;
    logic in_ready, blk_start, blk_done;
    logic signed [24:0] d1, d2, d3, d4;
    logic [3:0] lane_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    idct4_skew_feeder #(.IN_W(16), .OUT_W(25)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_c0      (in_c0),
        .in_c1      (in_c1),
        .in_c2      (in_c2),
        .in_c3      (in_c3),
        .d_out_1    (d1),
        .d_out_2    (d2),
        .d_out_3    (d3),
        .d_out_4    (d4),
        .lane_valid (lane_valid),
        .blk_start  (blk_start),
        .blk_done   (blk_done)
    );

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Block model: a block drains starting one edge after it completes, or
    // seven edges after the previous drain started, whichever is later.
    int e_cnt = 0;
    int nblk = 0;
    int mdata [32][4][4];
    int mstart [32];
    int part [4][4];
    int prow = 0;
    int last_start = -100;
    bit mready = 1'b0;

    initial begin
        int cnt, s;
        forever begin
            @(posedge clk);
            e_cnt++;
            if (!reset) begin
                nblk = 0; prow = 0; last_start = -100; mready = 1'b0;
            end else begin
                if (in_valid && mready) begin
                    part[prow][0] = int'(in_c0);
                    part[prow][1] = int'(in_c1);
                    part[prow][2] = int'(in_c2);
                    part[prow][3] = int'(in_c3);
                    prow++;
                    if (prow == 4) begin
                        prow = 0;
                        s = (e_cnt + 1 > last_start + 7) ? e_cnt + 1 : last_start + 7;
                        if (nblk < 32) begin
                            mdata[nblk] = part;
                            mstart[nblk] = s;
                            nblk++;
                        end
                        last_start = s;
                    end
                end
                cnt = 0;
                for (int b = 0; b < nblk; b++)
                    if (mstart[b] + 7 > e_cnt) cnt++;
                mready = (cnt < 2);
            end
        end
    end

    initial begin
        int ev [4];
        logic [3:0] elv;
        logic est, edn;
        int t, c;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) ev[k] = 0;
            elv = '0; est = 1'b0; edn = 1'b0;
            if (reset) begin
                for (int b = 0; b < nblk; b++) begin
                    if (mstart[b] <= e_cnt && e_cnt <= mstart[b] + 6) begin
                        t = e_cnt - mstart[b];
                        est = (t == 0);
                        edn = (t == 6);
                        for (int k = 0; k < 4; k++) begin
                            c = t - k;
                            if (c >= 0 && c <= 3) begin
                                ev[k] = mdata[b][k][c];
                                elv[k] = 1'b1;
                            end
                        end
                    end
                end
            end
            chk("cyc_d_out_1", d1, ev[0]);
            chk("cyc_d_out_2", d2, ev[1]);
            chk("cyc_d_out_3", d3, ev[2]);
            chk("cyc_d_out_4", d4, ev[3]);
            chk("cyc_lane_valid", lane_valid, elv);
            chk("cyc_blk_start", blk_start, est);
            chk("cyc_blk_done", blk_done, edn);
            chk("cyc_in_ready", in_ready, reset ? mready : 1'b0);
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_row(input int r [4]);
        in_valid = 1'b1;
        in_c0 = 16'(r[0]); in_c1 = 16'(r[1]); in_c2 = 16'(r[2]); in_c3 = 16'(r[3]);
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        checks++; errors++;
        $display("FAIL accept_timeout: got no in_ready in 200 cycles required in_ready=1");
    endtask

    task automatic send_block(input int blk [4][4], input bit gaps);
        for (int r = 0; r < 4; r++) begin
            send_row(blk[r]);
            in_valid = 1'b0;
            if (gaps && r < 3) @(negedge clk);
        end
    endtask

    int blk_a [4][4], blk_b [4][4], blk_c [4][4], blk_d [4][4], blk_e [4][4], blk_n [4][4];

    initial begin
        bit seen;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                blk_a[r][c] = 10 * r + c + 1;
                blk_b[r][c] = 100 + 10 * r + c;
                blk_c[r][c] = -(200 + 10 * r + c);
                blk_d[r][c] = 300 + 10 * r + c;
                blk_e[r][c] = -7 * (10 * r + c + 1);
                blk_n[r][c] = 50 + 4 * r + c;
            end
        blk_n[0][0] = -1;
        blk_n[3][3] = -32768;

        // Reset held with a beat offered
        in_valid = 1'b1; in_c0 = 16'd7; in_c1 = 16'd7; in_c2 = 16'd7; in_c3 = 16'd7;
        repeat (4) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_d_out_1", d1, 0);
        chk("rst_lane_valid", lane_valid, 0);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_release", in_ready, 1);

        // Single block, back-to-back rows
        send_block(blk_a, 1'b0);
        @(negedge clk);
        chk("a_t0_start", blk_start, 1);
        chk("a_t0_d1", d1, 1);
        chk("a_t0_d2", d2, 0);
        chk("a_t0_lv", lane_valid, 4'b0001);
        @(negedge clk);
        chk("a_t1_d1", d1, 2);
        chk("a_t1_d2", d2, 11);
        chk("a_t1_lv", lane_valid, 4'b0011);
        repeat (2) @(negedge clk);
        chk("a_t3_d1", d1, 4);
        chk("a_t3_d2", d2, 13);
        chk("a_t3_d3", d3, 22);
        chk("a_t3_d4", d4, 31);
        chk("a_t3_lv", lane_valid, 4'b1111);
        repeat (3) @(negedge clk);
        chk("a_t6_d1", d1, 0);
        chk("a_t6_d4", d4, 34);
        chk("a_t6_lv", lane_valid, 4'b1000);
        chk("a_t6_done", blk_done, 1);
        @(negedge clk);
        chk("a_after_d4", d4, 0);
        chk("a_after_lv", lane_valid, 0);

        // Negative extremes
        send_block(blk_n, 1'b0);
        @(negedge clk);
        chk("neg_d1_bits", $unsigned(d1), 25'h1FFFFFF);
        repeat (6) @(negedge clk);
        chk("neg_d4_bits", $unsigned(d4), 25'h1FF8000);
        chk("neg_t6_done", blk_done, 1);
        @(negedge clk);

        // Two blocks back-to-back, third offered while stalled
        send_block(blk_b, 1'b0);
        send_block(blk_c, 1'b0);
        chk("ready_low_after_8", in_ready, 0);
        in_valid = 1'b1;
        in_c0 = 16'(blk_d[0][0]); in_c1 = 16'(blk_d[0][1]);
        in_c2 = 16'(blk_d[0][2]); in_c3 = 16'(blk_d[0][3]);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = blk_done;
        end
        chk("b_done_seen", seen, 1);
        chk("b_done_ready", in_ready, 0);
        @(negedge clk);
        chk("c_no_bubble_start", blk_start, 1);
        chk("c_t0_d1", d1, blk_c[0][0]);
        chk("ready_back", in_ready, 1);
        send_block(blk_d, 1'b0);
        repeat (25) @(negedge clk);

        // Gapped valid
        send_block(blk_e, 1'b1);
        @(negedge clk);
        chk("gap_start", blk_start, 1);
        chk("gap_t0_d1", d1, blk_e[0][0]);
        repeat (10) @(negedge clk);

        // Reset mid-drain at t=3 with the second block FULL
        send_block(blk_a, 1'b0);
        send_block(blk_b, 1'b0);
        chk("pre_rst_lv", lane_valid, 4'b1111);
        chk("pre_rst_d4", d4, blk_a[3][0]);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_d1", d1, 0);
        chk("async_rst_d4", d4, 0);
        chk("async_rst_lv", lane_valid, 0);
        chk("async_rst_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_stale_lv", lane_valid, 0);
        send_block(blk_c, 1'b0);
        @(negedge clk);
        chk("post_rst_start", blk_start, 1);
        chk("post_rst_d1", d1, blk_c[0][0]);
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/idct4_skew_feeder.md
Name: idct4_skew_feeder

Overview:
- Upstream feeder for the 4-point systolic IDCT column element.
- Accepts a 4x4 coefficient block one row (4 coefficients) per beat over a valid/ready handshake and stores it in a ping-pong register bank.
- Drains each block column by column, diagonally skewed, so that element row k of column j reaches IDCT input lane k+1 exactly k cycles after lane 1.
- Unused lane slots are driven to zero, so the downstream accumulate chain adds nothing for them.

Parameters:
- IN_W, 16, signed coefficient width at the input.
- OUT_W, 25, signed lane width at the output; matches the IDCT element input.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous reset, active-low (asserted at 0)
- in_valid  input  1  a row beat is presented
- in_ready  output  1  the feeder can accept a row beat this cycle
- in_c0..in_c3  input  IN_W each  row coefficients, column 0..3, signed
- d_out_1..d_out_4  output  OUT_W each  skewed lane outputs; connect to IDCT d_in_1..d_in_4
- lane_valid  output  4  bit k=1 when d_out_(k+1) carries a real element
- blk_start  output  1  high for the cycle when column 0 / row 0 appears on lane 1
- blk_done  output  1  high for the cycle when column 3 / row 3 appears on lane 4

Behaviour:
- Reset (reset=0, async): all outputs 0, in_ready 0 while asserted; both banks EMPTY; wr_sel=0, rd_sel=0, wr_row=0; reader IDLE. A partial block is discarded. in_ready may rise on the first edge after release.
- Bank state per bank: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Write side:
  - in_ready = 1 when bank[wr_sel] is EMPTY or FILLING.
  - A beat is accepted when in_valid & in_ready at the rising edge.
  - An accepted beat stores in_c0..3 into row wr_row and increments wr_row.
  - On row 3: wr_row wraps to 0, the bank becomes FULL, wr_sel toggles.
  - in_valid with in_ready=0 is held by the source and not consumed.
- Read side, states IDLE and DRAIN, counter t in 0..6:
  - IDLE: when bank[rd_sel] is FULL at an edge, go to DRAIN with t=0 and load the t=0 outputs at that same edge.
  - DRAIN at step t: lane k (0..3) = sign-extended bank[rd_sel][row k][col t-k] if 0<=t-k<=3, else 0 with lane_valid[k]=0.
  - blk_start = (t==0); blk_done = (t==6).
  - After t=6, at the next edge: bank[rd_sel] becomes EMPTY and rd_sel toggles. If the other bank is FULL, load its t=0 step on that same edge (no bubble); otherwise go IDLE and zero all outputs and lane_valid.
- Latency: 4th beat accepted at edge N -> first element on lane 1 after edge N+1; the last element appears after edge N+7.
- Throughput: 7 cycles per block drain versus a minimum of 4 write beats, so the source stalls when both banks are occupied. The freed bank may accept a beat on the edge after it returns to EMPTY.
- Simultaneous events: writes to bank[wr_sel] and drain of bank[rd_sel] are independent. wr_sel==rd_sel is legal only when that bank is FILLING/EMPTY (write) or FULL/DRAINING (read); the states guarantee no overlap.
- Arithmetic: lane outputs are IN_W values sign-extended to OUT_W. No scaling or rounding here; rounding stays in the IDCT stage.
- All outputs are registered; no combinational path from in_* to d_out_*. in_ready is a registered-state function only.

Decomposition:
- Shared package idct_pkg holds:
  - constants N=4, DRAIN_LEN=7, IDCT_IN_W=25;
  - typedef coeff_t (signed IN_W) and lane_t (signed OUT_W);
  - enum bank_state_t {EMPTY, FILLING, FULL, DRAINING};
  - enum rd_state_t {IDLE, DRAIN}.
- Sub-module idct_blk_bank: one 4x4 register bank with a row-write port and four element-read ports (row k, column index). Instantiate twice.

Test Plan:
- Reset: hold reset=0 with in_valid=1 -> in_ready=0, all d_out and lane_valid 0, nothing stored. Release, then write one block -> normal drain.
- Single block, rows {1,2,3,4}, {11,12,13,14}, {21,22,23,24}, {31,32,33,34}, written on back-to-back beats:
  - t=0: lanes (1,0,0,0), lane_valid 0001, blk_start 1
  - t=1: (2,11,0,0), 0011
  - t=3: (4,13,22,31), 1111
  - t=6: (0,0,0,34), 1000, blk_done 1
  - Cycle after t=6: all 0.
- Negative values: in_c0=-1 (16'hFFFF) in row 0 -> d_out_1 = 25'h1FFFFFF at t=0; in_c3=-32768 in row 3 -> d_out_4 = 25'h1FF8000 at t=6.
- Back-to-back blocks with in_valid held high:
  - Blocks 1 and 2 are accepted in 8 beats; in_ready falls after the 8th.
  - Block 2's t=0 immediately follows block 1's t=6, with no idle cycle.
  - in_ready rises again one edge after block 1's bank frees.
- Backpressure and gaps: in_valid toggling 1,0,1,0,... -> rows land in order, drain starts one edge after the 4th accepted beat. A beat offered while in_ready=0 is not lost: it is accepted once in_ready rises.
- Reset mid-drain at t=3 with a second block FULL -> outputs 0 immediately (async). After release, no stale data emerges; a new single block drains correctly.
